// File: rtl/sram_bank.sv
// Single-port synchronous SRAM bank with byte-enable writes, 1-cycle registered reads and a post-reset clear sweep.
// Latency: reads return 1 cycle after acceptance. f_ready is low during the DEPTH-cycle sweep; req is ignored there. Optional macro: SRAM_PARITY_EN.
module sram_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 128
) (
    input  logic                  retrieve_clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     datain,
    output logic [DATA_W-1:0]     dataout,
    output logic                  rvalid,
    output logic                  f_ready,
    output logic                  addr_err
`ifdef SRAM_PARITY_EN
    ,
    output logic                  par_err
`endif
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

    typedef enum logic {INIT, IDLE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   cnt;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [IDX_W-1:0]   idx;
    logic               in_range;
    logic               sweep_wr;
    logic               accept;
    logic               wr_acc;
    logic               rd_acc;

    assign idx      = addr[IDX_W-1:0];
    // Full-width compare: addresses at or beyond DEPTH never alias into the array
    assign in_range = ({1'b0, addr} < DEPTH_L);
    assign accept   = req & f_ready & ~rst;
    assign wr_acc   = accept & we;
    assign rd_acc   = accept & ~we;

    always_comb begin
        state_nxt = state;
        f_ready   = 1'b0;
        sweep_wr  = 1'b0;
        case (state)
            INIT: begin
                sweep_wr = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                f_ready = 1'b1;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    always_ff @(posedge retrieve_clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (sweep_wr) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Storage is not reset; the sweep clears it after every reset
    always_ff @(posedge retrieve_clk) begin
        if (!rst) begin
            if (sweep_wr) begin
                mem[cnt] <= '0;
            end else if (wr_acc && in_range) begin
                for (int k = 0; k < NB; k++) begin
                    if (be[k]) begin
                        mem[idx][8*k +: 8] <= datain[8*k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge retrieve_clk) begin
        if (rst) begin
            dataout  <= '0;
            rvalid   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rvalid   <= rd_acc;
            addr_err <= accept & ~in_range;
            if (rd_acc) begin
                dataout <= in_range ? mem[idx] : '0;
            end
        end
    end

`ifdef SRAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] rd_par;

    always_comb begin
        rd_par = '0;
        for (int k = 0; k < NB; k++) begin
            rd_par[k] = ^mem[idx][8*k +: 8];
        end
    end

    always_ff @(posedge retrieve_clk) begin
        if (!rst) begin
            if (sweep_wr) begin
                par_mem[cnt] <= '0;
            end else if (wr_acc && in_range) begin
                for (int k = 0; k < NB; k++) begin
                    if (be[k]) begin
                        par_mem[idx][k] <= ^datain[8*k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge retrieve_clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else begin
            par_err <= rd_acc & in_range & (|(rd_par ^ par_mem[idx]));
        end
    end
`endif

endmodule

// File: tb/tb_sram_bank.sv
// Directed bench: two banks (DEPTH 128 and 100) share stimulus; boundary behaviour is compared between them.
module tb_sram_bank;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] datain;

    logic [31:0] d_a, d_b;
    logic        rv_a, rv_b, fr_a, fr_b, ae_a, ae_b;
`ifdef SRAM_PARITY_EN
    logic        pe_a, pe_b;
`endif

    int n_chk = 0;
    int n_err = 0;

    sram_bank #(.DATA_W(32), .ADDR_W(8), .DEPTH(128)) u128 (
        .retrieve_clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be),
        .datain(datain), .dataout(d_a), .rvalid(rv_a), .f_ready(fr_a), .addr_err(ae_a)
`ifdef SRAM_PARITY_EN
        , .par_err(pe_a)
`endif
    );

    sram_bank #(.DATA_W(32), .ADDR_W(8), .DEPTH(100)) u100 (
        .retrieve_clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be),
        .datain(datain), .dataout(d_b), .rvalid(rv_b), .f_ready(fr_b), .addr_err(ae_b)
`ifdef SRAM_PARITY_EN
        , .par_err(pe_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; we = w; addr = a; datain = d; be = b;
        tick();
        req = 1'b0; we = 1'b0;
    endtask

    task automatic sweep_check(input string tag);
        for (int i = 0; i < 130; i++) begin
            chk({tag, "_fr128"}, 32'(fr_a), 32'(i >= 128));
            chk({tag, "_fr100"}, 32'(fr_b), 32'(i >= 100));
            chk({tag, "_rv128"}, 32'(rv_a), 32'd0);
            chk({tag, "_rv100"}, 32'(rv_b), 32'd0);
            if (i >= 99) req = 1'b0;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; datain = '0;
        tick();
        chk("rst_fr",  32'(fr_a), 32'd0);
        chk("rst_rv",  32'(rv_b), 32'd0);
        chk("rst_do",  d_a, 32'd0);
        chk("rst_ae",  32'(ae_a), 32'd0);

        // req held high during the sweep: mixed reads and writes to addr 5 must be ignored
        rst = 1'b0; req = 1'b1; addr = 8'd5; be = 4'hF; datain = 32'hFFFF_FFFF;
        fork
            begin
                for (int j = 0; j < 130; j++) begin
                    we = j[0];
                    @(posedge clk);
                end
            end
        join_none
        sweep_check("init");
        disable fork;

        issue(1'b0, 8'd5, 32'h0, 4'h0);
        chk("rd5_do128", d_a, 32'd0);
        chk("rd5_rv128", 32'(rv_a), 32'd1);
        chk("rd5_do100", d_b, 32'd0);
        chk("rd5_rv100", 32'(rv_b), 32'd1);
        tick();
        chk("rv_pulse", 32'(rv_a), 32'd0);

        issue(1'b1, 8'd3, 32'hDEAD_BEEF, 4'hF);
        chk("wr_rv", 32'(rv_a), 32'd0);
        issue(1'b0, 8'd3, 32'h0, 4'h0);
        chk("raw_do", d_a, 32'hDEAD_BEEF);
        chk("raw_rv", 32'(rv_a), 32'd1);

        issue(1'b1, 8'd3, 32'h1122_3344, 4'b0101);
        issue(1'b0, 8'd3, 32'h0, 4'h0);
        chk("be_do128", d_a, 32'hDE22_BE44);
        chk("be_do100", d_b, 32'hDE22_BE44);
        tick();
        chk("hold_do", d_a, 32'hDE22_BE44);
        chk("hold_rv", 32'(rv_a), 32'd0);

        issue(1'b1, 8'd3, 32'h0, 4'h0);
        issue(1'b0, 8'd3, 32'h0, 4'h0);
        chk("be0_do", d_a, 32'hDE22_BE44);

        issue(1'b1, 8'd120, 32'hAAAA_AAAA, 4'hF);
        chk("oorw_ae100", 32'(ae_b), 32'd1);
        chk("oorw_ae128", 32'(ae_a), 32'd0);
        chk("oorw_rv100", 32'(rv_b), 32'd0);
        tick();
        chk("ae_pulse", 32'(ae_b), 32'd0);
        issue(1'b0, 8'd120, 32'h0, 4'h0);
        chk("oorr_do100", d_b, 32'd0);
        chk("oorr_rv100", 32'(rv_b), 32'd1);
        chk("oorr_ae100", 32'(ae_b), 32'd1);
        chk("oorr_do128", d_a, 32'hAAAA_AAAA);
        chk("oorr_ae128", 32'(ae_a), 32'd0);

        // Last legal word and first illegal word of the 100-deep bank
        issue(1'b1, 8'd99, 32'h1234_5678, 4'hF);
        chk("w99_ae100", 32'(ae_b), 32'd0);
        issue(1'b0, 8'd99, 32'h0, 4'h0);
        chk("r99_do100", d_b, 32'h1234_5678);
        chk("r99_ae100", 32'(ae_b), 32'd0);
        issue(1'b0, 8'd100, 32'h0, 4'h0);
        chk("r100_ae100", 32'(ae_b), 32'd1);
        chk("r100_do100", d_b, 32'd0);
        chk("r100_do128", d_a, 32'd0);
        issue(1'b0, 8'd255, 32'h0, 4'h0);
        chk("r255_ae128", 32'(ae_a), 32'd1);
        chk("r255_do128", d_a, 32'd0);

        // Reset in the accept cycle of a read drops it and restarts the sweep
        issue(1'b0, 8'd3, 32'h0, 4'h0);
        chk("pre_rst_do", d_a, 32'hDE22_BE44);
        rst = 1'b1;
        issue(1'b0, 8'd3, 32'h0, 4'h0);
        chk("mid_rst_rv", 32'(rv_a), 32'd0);
        chk("mid_rst_fr", 32'(fr_a), 32'd0);
        chk("mid_rst_do", d_a, 32'd0);
        rst = 1'b0;
        sweep_check("resweep");
        issue(1'b0, 8'd3, 32'h0, 4'h0);
        chk("clr3_do128", d_a, 32'd0);
        chk("clr3_rv128", 32'(rv_a), 32'd1);
        issue(1'b0, 8'd99, 32'h0, 4'h0);
        chk("clr99_do100", d_b, 32'd0);

`ifdef SRAM_PARITY_EN
        issue(1'b1, 8'd7, 32'h0F0F_0F0F, 4'hF);
        issue(1'b0, 8'd7, 32'h0, 4'h0);
        chk("par_ok", 32'(pe_a), 32'd0);
        u128.mem[7] = u128.mem[7] ^ 32'h1;
        issue(1'b0, 8'd7, 32'h0, 4'h0);
        chk("par_err", 32'(pe_a), 32'd1);
        chk("par_rv", 32'(rv_a), 32'd1);
        chk("par_do", d_a, 32'h0F0F_0F0E);
        tick();
        chk("par_pulse", 32'(pe_a), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got %0d exp %0d", 0, 1);
        $fatal(1);
    end

endmodule
